// File: rtl/addatone_dac_pkg.sv
// Shared definitions for the DAC SPI link (transmit side and receive-side model).
//   CMD_CHANNEL_A/B : command bytes selecting the DAC channel
//   SAMPLE_OFFSET   : offset code that corresponds to signed sample 0
//   FRAME_BITS      : bits per frame (CS low period)
//   rx_state_e      : receiver FSM states
//   dac_frame_t     : frame payload {command, offset code}
//   code_to_sample  : offset code -> signed sample with positive saturation
package addatone_dac_pkg;

   localparam int unsigned CMD_W      = 8;
   localparam int unsigned CODE_W     = 16;
   localparam int unsigned FRAME_BITS = CMD_W + CODE_W;
   localparam int unsigned COUNT_W    = 5;

   localparam logic [CMD_W-1:0]  CMD_CHANNEL_A = 8'b0011_0001;
   localparam logic [CMD_W-1:0]  CMD_CHANNEL_B = 8'b0011_0010;
   localparam logic [CODE_W-1:0] SAMPLE_OFFSET = 16'h7FFF;
   localparam logic [CODE_W-1:0] SAMPLE_MAX    = 16'h7FFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [CODE_W-1:0] code;
   } dac_frame_t;

   // 17-bit subtraction; only code 16'hFFFF lands above +32767 and is clamped.
   function automatic logic [CODE_W-1:0] code_to_sample(input logic [CODE_W-1:0] code);
      logic [CODE_W:0]   diff;
      logic [CODE_W-1:0] result;
      diff = {1'b0, code} - {1'b0, SAMPLE_OFFSET};
      if (!diff[CODE_W] && diff[CODE_W-1]) begin
         result = SAMPLE_MAX;
      end else begin
         result = diff[CODE_W-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Brings the asynchronous SPI pins into the i_Clock domain.
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   cs, sck, data     : raw SPI pins
//   cs_rise_c         : combinational strobe, synced CS went 0->1
//   cs_fall_c         : combinational strobe, synced CS went 1->0
//   sck_rise_c        : combinational strobe, synced SCK went 0->1
//   data_sync         : synced data, aligned with the SCK strobe
module spi_input_sync (
   input  logic clock,
   input  logic reset,
   input  logic cs,
   input  logic sck,
   input  logic data,
   output logic cs_rise_c,
   output logic cs_fall_c,
   output logic sck_rise_c,
   output logic data_sync
);

   logic [1:0] cs_meta;
   logic [1:0] sck_meta;
   logic [1:0] data_meta;
   logic       cs_prev;
   logic       sck_prev;

   // CS chain resets low: a CS already low at reset release produces no
   // falling edge, so a half-sent frame is ignored until CS cycles high.
   always_ff @(posedge clock) begin
      if (reset) begin
         cs_meta   <= 2'b00;
         sck_meta  <= 2'b00;
         data_meta <= 2'b00;
         cs_prev   <= 1'b0;
         sck_prev  <= 1'b0;
      end else begin
         cs_meta   <= {cs_meta[0], cs};
         sck_meta  <= {sck_meta[0], sck};
         data_meta <= {data_meta[0], data};
         cs_prev   <= cs_meta[1];
         sck_prev  <= sck_meta[1];
      end
   end

   assign cs_rise_c  =  cs_meta[1]  & ~cs_prev;
   assign cs_fall_c  = ~cs_meta[1]  &  cs_prev;
   assign sck_rise_c =  sck_meta[1] & ~sck_prev;
   assign data_sync  =  data_meta[1];

endmodule

// File: rtl/dac_spi_receiver.sv
// SPI-slave end of the dual-channel DAC link. Decodes 24-bit frames
// {command, offset code}, routes them to channel A/B and converts codes back
// to signed samples. Result pulses appear 4 i_Clock cycles after CS rises.
// Ports:
//   i_Clock, i_Reset           : system clock, synchronous active-high reset
//   i_SPI_CS/Clock/Data        : SPI slave pins (CS active low, SCK idle low)
//   o_Sample_A, o_Sample_B     : last good signed sample per channel
//   o_Valid_A, o_Valid_B       : 1-cycle update pulses
//   o_Pair_Valid               : B frame directly followed a good A frame
//   o_Frame_Error              : wrong bit count or unknown command
//   o_Busy                     : frame in progress
module dac_spi_receiver
   import addatone_dac_pkg::*;
(
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic              i_SPI_CS,
   input  logic              i_SPI_Clock,
   input  logic              i_SPI_Data,
   output logic [CODE_W-1:0] o_Sample_A,
   output logic [CODE_W-1:0] o_Sample_B,
   output logic              o_Valid_A,
   output logic              o_Valid_B,
   output logic              o_Pair_Valid,
   output logic              o_Frame_Error,
   output logic              o_Busy
);

   localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;
   localparam logic [COUNT_W-1:0] COUNT_GOOD = COUNT_W'(FRAME_BITS);

   logic cs_rise_c;
   logic cs_fall_c;
   logic sck_rise_c;
   logic data_sync;

   rx_state_e state;
   rx_state_e next_state;

   logic [FRAME_BITS-1:0] shift_reg;
   logic [FRAME_BITS-1:0] shift_next;
   logic [COUNT_W-1:0]    bit_count;
   logic [COUNT_W-1:0]    count_next;
   logic                  pair_flag;
   logic                  pair_next;
   logic [CODE_W-1:0]     sample_a_next;
   logic [CODE_W-1:0]     sample_b_next;
   logic                  valid_a_next;
   logic                  valid_b_next;
   logic                  pair_valid_next;
   logic                  frame_error_next;
   logic                  busy_next;
   dac_frame_t            frame;

   spi_input_sync u_sync (
      .clock      (i_Clock),
      .reset      (i_Reset),
      .cs         (i_SPI_CS),
      .sck        (i_SPI_Clock),
      .data       (i_SPI_Data),
      .cs_rise_c  (cs_rise_c),
      .cs_fall_c  (cs_fall_c),
      .sck_rise_c (sck_rise_c),
      .data_sync  (data_sync)
   );

   assign frame = shift_reg;

   // State register
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; IDLE reacts only to a falling edge, never a level
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (cs_fall_c) next_state = ST_SHIFT;
         ST_SHIFT: if (cs_rise_c) next_state = ST_CHECK;
         ST_CHECK: next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      shift_next       = shift_reg;
      count_next       = bit_count;
      pair_next        = pair_flag;
      sample_a_next    = o_Sample_A;
      sample_b_next    = o_Sample_B;
      valid_a_next     = 1'b0;
      valid_b_next     = 1'b0;
      pair_valid_next  = 1'b0;
      frame_error_next = 1'b0;
      busy_next        = (next_state != ST_IDLE);

      case (state)
         ST_IDLE: begin
            if (cs_fall_c) begin
               shift_next = '0;
               count_next = '0;
            end
         end
         ST_SHIFT: begin
            // An SCK edge coinciding with CS rise belongs to no frame
            if (sck_rise_c && !cs_rise_c) begin
               shift_next = {shift_reg[FRAME_BITS-2:0], data_sync};
               if (bit_count != COUNT_MAX) begin
                  count_next = bit_count + COUNT_W'(1);
               end
            end
         end
         ST_CHECK: begin
            if (bit_count != COUNT_GOOD) begin
               frame_error_next = 1'b1;
               pair_next        = 1'b0;
            end else if (frame.cmd == CMD_CHANNEL_A) begin
               sample_a_next = code_to_sample(frame.code);
               valid_a_next  = 1'b1;
               pair_next     = 1'b1;
            end else if (frame.cmd == CMD_CHANNEL_B) begin
               sample_b_next   = code_to_sample(frame.code);
               valid_b_next    = 1'b1;
               pair_valid_next = pair_flag;
               pair_next       = 1'b0;
            end else begin
               frame_error_next = 1'b1;
               pair_next        = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         shift_reg     <= '0;
         bit_count     <= '0;
         pair_flag     <= 1'b0;
         o_Sample_A    <= '0;
         o_Sample_B    <= '0;
         o_Valid_A     <= 1'b0;
         o_Valid_B     <= 1'b0;
         o_Pair_Valid  <= 1'b0;
         o_Frame_Error <= 1'b0;
         o_Busy        <= 1'b0;
      end else begin
         shift_reg     <= shift_next;
         bit_count     <= count_next;
         pair_flag     <= pair_next;
         o_Sample_A    <= sample_a_next;
         o_Sample_B    <= sample_b_next;
         o_Valid_A     <= valid_a_next;
         o_Valid_B     <= valid_b_next;
         o_Pair_Valid  <= pair_valid_next;
         o_Frame_Error <= frame_error_next;
         o_Busy        <= busy_next;
      end
   end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: directed table of frames, reset-mid-frame
// sequence, then random frames against a behavioural model.
module tb_dac_spi_receiver;

   localparam int PH = 4;   // SCK half period in i_Clock cycles

   logic        clock = 1'b0;
   logic        reset;
   logic        cs;
   logic        sck;
   logic        data;
   logic [15:0] sample_a;
   logic [15:0] sample_b;
   logic        valid_a;
   logic        valid_b;
   logic        pair_valid;
   logic        frame_error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] code;
      int          nbits;
      logic        va;
      logic        vb;
      logic        pv;
      logic        fe;
      logic [15:0] sa;
      logic [15:0] sb;
   } vec_t;

   vec_t vecs[13];

   // Behavioural model state
   logic [15:0] m_sa;
   logic [15:0] m_sb;
   bit          m_last_good_a;

   dac_spi_receiver dut (
      .i_Clock       (clock),
      .i_Reset       (reset),
      .i_SPI_CS      (cs),
      .i_SPI_Clock   (sck),
      .i_SPI_Data    (data),
      .o_Sample_A    (sample_a),
      .o_Sample_B    (sample_b),
      .o_Valid_A     (valid_a),
      .o_Valid_B     (valid_b),
      .o_Pair_Valid  (pair_valid),
      .o_Frame_Error (frame_error),
      .o_Busy        (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [15:0] model_conv(input logic [15:0] code);
      int s;
      s = int'(code) - 32767;
      if (s > 32767) s = 32767;
      return 16'(s);
   endfunction

   // Applies one frame to the model, returns expected pulses
   task automatic model_frame(input logic [7:0] cmd, input logic [15:0] code, input int nbits,
                              output logic va, output logic vb, output logic pv, output logic fe);
      va = 0; vb = 0; pv = 0; fe = 0;
      if (nbits != 24) begin
         fe = 1; m_last_good_a = 0;
      end else if (cmd == 8'h31) begin
         va = 1; m_sa = model_conv(code); m_last_good_a = 1;
      end else if (cmd == 8'h32) begin
         vb = 1; m_sb = model_conv(code); pv = m_last_good_a; m_last_good_a = 0;
      end else begin
         fe = 1; m_last_good_a = 0;
      end
   endtask

   task automatic shift_bits(input logic [31:0] bits, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         data = bits[i];
         wait_cyc(PH);
         sck = 1'b1;
         wait_cyc(PH);
         sck = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [15:0] code, input int nbits);
      logic [23:0] f;
      f = {cmd, code};
      @(negedge clock);
      cs = 1'b0;
      wait_cyc(PH);
      if (nbits == 23)      shift_bits({9'd0, f[23:1]}, 23);
      else if (nbits == 25) shift_bits({7'd0, f, 1'b0}, 25);
      else                  shift_bits({8'd0, f}, 24);
      wait_cyc(PH);
   endtask

   // Raises CS and checks the exact 4-cycle result latency
   task automatic end_and_check(input string tag, input logic va, input logic vb, input logic pv,
                                input logic fe, input logic [15:0] sa, input logic [15:0] sb);
      check({tag, " busy_in_frame"}, 32'(busy), 32'd1);
      cs = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clock); #1;
         check({tag, " early_pulse"}, {valid_a, valid_b, pair_valid, frame_error}, 32'd0);
      end
      @(posedge clock); #1;
      check({tag, " valid_a"}, 32'(valid_a), 32'(va));
      check({tag, " valid_b"}, 32'(valid_b), 32'(vb));
      check({tag, " pair_valid"}, 32'(pair_valid), 32'(pv));
      check({tag, " frame_error"}, 32'(frame_error), 32'(fe));
      check({tag, " sample_a"}, 32'(sample_a), 32'(sa));
      check({tag, " sample_b"}, 32'(sample_b), 32'(sb));
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      check({tag, " pulse_width"}, {valid_a, valid_b, pair_valid, frame_error}, 32'd0);
      wait_cyc(PH);
   endtask

   task automatic do_reset;
      @(negedge clock);
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      m_sa = 16'h0; m_sb = 16'h0; m_last_good_a = 0;
   endtask

   initial begin
      logic va, vb, pv, fe;
      logic [7:0]  cmd;
      logic [15:0] code;
      int          nb;
      int          r;

      // cmd, code, nbits, va, vb, pv, fe, sample_a, sample_b
      vecs[0]  = '{8'h31, 16'h7FFF, 24, 1, 0, 0, 0, 16'h0000, 16'h0000};
      vecs[1]  = '{8'h32, 16'hFFFE, 24, 0, 1, 1, 0, 16'h0000, 16'h7FFF};
      vecs[2]  = '{8'h32, 16'h0000, 24, 0, 1, 0, 0, 16'h0000, 16'h8001};
      vecs[3]  = '{8'h31, 16'hFFFF, 24, 1, 0, 0, 0, 16'h7FFF, 16'h8001};
      vecs[4]  = '{8'h31, 16'h1234, 23, 0, 0, 0, 1, 16'h7FFF, 16'h8001};
      vecs[5]  = '{8'h32, 16'h1234, 25, 0, 0, 0, 1, 16'h7FFF, 16'h8001};
      vecs[6]  = '{8'h31, 16'h0001, 24, 1, 0, 0, 0, 16'h8002, 16'h8001};
      vecs[7]  = '{8'h32, 16'h8000, 24, 0, 1, 1, 0, 16'h8002, 16'h0001};
      vecs[8]  = '{8'h33, 16'h1234, 24, 0, 0, 0, 1, 16'h8002, 16'h0001};
      vecs[9]  = '{8'h32, 16'h7FFF, 24, 0, 1, 0, 0, 16'h8002, 16'h0000};
      vecs[10] = '{8'h31, 16'h8001, 24, 1, 0, 0, 0, 16'h0002, 16'h0000};
      vecs[11] = '{8'h31, 16'h7FFE, 24, 1, 0, 0, 0, 16'hFFFF, 16'h0000};
      vecs[12] = '{8'h32, 16'h7FFD, 24, 0, 1, 1, 0, 16'hFFFF, 16'hFFFE};

      cs = 1'b1; sck = 1'b0; data = 1'b0; reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(3);
      #1;
      check("reset outputs", {sample_a, sample_b}, 32'd0);
      check("reset pulses", {valid_a, valid_b, pair_valid, frame_error, busy}, 32'd0);

      // Directed table
      for (int i = 0; i < 13; i++) begin
         send_frame(vecs[i].cmd, vecs[i].code, vecs[i].nbits);
         end_and_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].pv,
                       vecs[i].fe, vecs[i].sa, vecs[i].sb);
      end

      // Reset after 10 bits with CS held low; the remainder must be ignored
      @(negedge clock);
      cs = 1'b0;
      wait_cyc(PH);
      shift_bits(32'h0000_0031 << 2, 10);
      reset = 1'b1;
      wait_cyc(2);
      reset = 1'b0;
      wait_cyc(2);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset samples", {sample_a, sample_b}, 32'd0);
      shift_bits(32'h0000_3FFF, 14);
      wait_cyc(PH);
      cs = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clock); #1;
         check("midreset no_pulse", {valid_a, valid_b, pair_valid, frame_error, busy}, 32'd0);
      end
      wait_cyc(PH);
      m_sa = 16'h0; m_sb = 16'h0; m_last_good_a = 0;
      send_frame(8'h31, 16'h8000, 24);
      end_and_check("after_reset", 1, 0, 0, 0, 16'h0001, 16'h0000);

      // Random frames against the model
      do_reset();
      wait_cyc(PH);
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 9));
         nb = (r == 0) ? 23 : (r == 1) ? 25 : 24;
         r = int'($urandom_range(0, 9));
         cmd = (r < 4) ? 8'h31 : (r < 8) ? 8'h32 : 8'($urandom);
         r = int'($urandom_range(0, 9));
         code = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
         model_frame(cmd, code, nb, va, vb, pv, fe);
         send_frame(cmd, code, nb);
         end_and_check($sformatf("rnd%0d cmd=%0h code=%0h n=%0d", n, cmd, code, nb),
                       va, vb, pv, fe, m_sa, m_sb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
